calc_engine: RTL and testbench
==============================

// Module: calc_engine
// PURPOSE
//  Parametrised keypad calculator core: digit/operator entry, add/sub/mul/div, chaining.
//  Sits between the keypad scanner (key_en/key strobes) and the display driver (out).
//  Adds to the prior calculator core: configurable operand width, a multi-cycle divider,
//  sign/error flags, clear, and result chaining.
// PARAMETERS
//  OPW   8          operand width in bits; max operand value 2**OPW-1
//  W     2*OPW      result/display width; must be >= 2*OPW
// PORTS
//  clk     in   1    system clock
//  rst     in   1    synchronous, active-high reset
//  key_en  in   1    one-cycle strobe, key valid
//  key     in   4    0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 clear, 15 reserved
//  equal   in   1    one-cycle strobe, evaluate
//  out     out  W    display value
//  neg     out  1    result is negative (out holds magnitude)
//  err     out  1    error state (divide by zero, chain overflow)
//  busy    out  1    computation in progress; keys except clear are ignored
//  valid   out  1    one-cycle pulse when a new result is loaded into out
// BEHAVIOUR
//  Reset: state IDLE; A=B=0; op=add; out=0; neg=err=busy=valid=0.
//  States: IDLE, OPA, OPB, CALC, RESULT, ERROR.
//  Digit entry: acc <= acc*10+d; if result > 2**OPW-1, the digit is dropped (acc unchanged).
//  IDLE  : digit -> OPA (A=d); operator -> OPB with A=0, op latched; equal ignored.
//  OPA   : digit -> accumulate A; operator -> OPB, op latched, B=0; equal -> RESULT, out=A.
//  OPB   : digit -> accumulate B; operator with no B digit -> replaces op;
//          operator after B digit ignored; equal -> CALC (with no B digit: B=0).
//  CALC  : add/sub/mul: 1 cycle, result in out on the cycle after the equal strobe is sampled
//          in CALC (latency 2 clk from equal). div: restoring divider, OPW+1 cycles in CALC;
//          B=0 -> ERROR after 1 cycle.
//          busy=1 throughout CALC. valid pulses on CALC->RESULT.
//  Arithmetic: add A+B (OPW+1 bits); sub: A>=B -> A-B, neg=0, else B-A, neg=1;
//          mul A*B (2*OPW bits); div floor(A/B), remainder discarded. All zero-extended to W.
//  RESULT: digit -> OPA, A=d, neg=0; operator -> chain: if neg=0 and result<=2**OPW-1,
//          A=result, go OPB; else ERROR; equal -> recompute with same op and B (repeat).
//  ERROR : err=1, out=0; only clear leaves it (to IDLE).
//  Display: out = A in OPA, B in OPB, result in CALC/RESULT (held), 0 in IDLE/ERROR.
//  Clear (key 14): from any state, including mid-divide, -> IDLE next cycle, same as reset
//          values. The divider is aborted and no valid pulse is issued.
//  Key 15: ignored in every state.
//  Simultaneous key_en and equal: key processed, equal dropped.
//  Strobes during busy are dropped and not queued.
//  rst mid-operation: divider aborted, all outputs to reset values on next edge.
// STRUCTURE
//  Package calc_pkg: key code localparams (KEY_ADD..KEY_CLR), op enum, state encoding.
//  Sub-module calc_divider: start/done handshake, OPW-bit restoring divider, abort input,
//  dbz flag. The FSM and datapath stay in calc_engine.
// TESTING (OPW=8, W=16)
//  Keys 1,2,3,add,4,5,equal -> valid pulse 2 clk after equal; out=168, neg=0.
//  Keys 2,5,6 -> third digit dropped (256>255); out=25. Then mul,2,5,5,equal -> out=6375.
//  Keys 7,sub,9,equal -> out=2, neg=1. Then add -> ERROR, err=1, out=0; clear -> IDLE, err=0.
//  Keys 2,0,0,div,7,equal -> busy=1 for 9 cycles, then out=28, valid. Same divide with clear
//      at cycle 4 -> IDLE, busy=0, no valid pulse.
//  Keys 9,div,0,equal -> ERROR, err=1. Keys 5,add,3,equal,equal -> out=8 then out=11.
//  key_en and equal asserted together in OPB -> digit accumulated, no CALC entry.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//   Shared definitions for the keypad calculator core: key codes delivered by
//   the keypad scanner, the arithmetic operator set, the controller state
//   encoding, and a helper that maps an operator key to its operator.
// ---------------------------------------------------------------------------
package calc_pkg;

  // Key codes 0-9 are decimal digits; the rest are commands.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_CLR       = 4'd14;
  localparam logic [3:0] KEY_RSV       = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPA,
    ST_OPB,
    ST_CALC,
    ST_RESULT,
    ST_ERROR
  } state_e;

  // Only meaningful for KEY_ADD..KEY_DIV; anything else maps to add.
  function automatic op_e key_to_op(input logic [3:0] key);
    op_e op;
    unique case (key)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_if.sv
// ---------------------------------------------------------------------------
// calc_if
//   Keypad-side strobes and display-side results of the calculator core.
//   master : keypad scanner / display driver side (drives key_en, key, equal)
//   slave  : calculator core (drives out, neg, err, busy, valid)
//   key_en  1  one-cycle strobe, key valid
//   key     4  key code (see calc_pkg)
//   equal   1  one-cycle strobe, evaluate
//   out     W  display value (magnitude)
//   neg     1  displayed result is negative
//   err     1  error state
//   busy    1  computation in progress
//   valid   1  one-cycle pulse when a computed result is loaded into out
// ---------------------------------------------------------------------------
interface calc_if #(
  parameter int W = 16
);
  logic         key_en;
  logic [3:0]   key;
  logic         equal;
  logic [W-1:0] out;
  logic         neg;
  logic         err;
  logic         busy;
  logic         valid;

  modport master (
    output key_en, key, equal,
    input  out, neg, err, busy, valid
  );

  modport slave (
    input  key_en, key, equal,
    output out, neg, err, busy, valid
  );
endinterface

// File: rtl/calc_divider.sv
// ---------------------------------------------------------------------------
// calc_divider
//   OPW-bit restoring divider, one quotient bit per cycle. The first bit is
//   produced in the start cycle, so o_done rises OPW cycles after i_start.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     i_start         begin a division (ignored while busy)
//     i_abort         drop any division in progress, no done pulse
//     i_dividend      OPW-bit dividend, sampled on i_start
//     i_divisor       OPW-bit divisor, sampled on i_start
//     o_busy          division in progress
//     o_done          one-cycle pulse, o_quotient is final
//     o_dbz           combinational: i_start with a zero divisor (no run)
//     o_quotient      floor(dividend / divisor); remainder is discarded
//   Requires OPW >= 2.
// ---------------------------------------------------------------------------
module calc_divider #(
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [OPW-1:0] i_dividend,
  input  logic [OPW-1:0] i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_dbz,
  output logic [OPW-1:0] o_quotient
);
  localparam int CW = $clog2(OPW + 1);

  logic [OPW:0]   r_rem;
  logic [OPW-1:0] r_quo;
  logic [OPW-1:0] r_div;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;

  logic [OPW:0]   w_src_rem;
  logic [OPW-1:0] w_src_quo;
  logic [OPW-1:0] w_src_div;
  logic [OPW:0]   w_shift;
  logic [OPW:0]   w_trial;
  logic [OPW:0]   w_rem_nxt;
  logic [OPW-1:0] w_quo_nxt;

  assign o_dbz = i_start && (i_divisor == '0);

  // One restoring step. On start the step works directly on the inputs so
  // the first quotient bit costs no extra cycle.
  always_comb begin
    w_src_rem = i_start ? '0         : r_rem;
    w_src_quo = i_start ? i_dividend : r_quo;
    w_src_div = i_start ? i_divisor  : r_div;
    w_shift   = {w_src_rem[OPW-1:0], w_src_quo[OPW-1]};
    w_trial   = w_shift - {1'b0, w_src_div};
    // A set MSB means the trial subtraction went negative: restore.
    if (w_trial[OPW]) begin
      w_rem_nxt = w_shift;
      w_quo_nxt = {w_src_quo[OPW-2:0], 1'b0};
    end else begin
      w_rem_nxt = w_trial;
      w_quo_nxt = {w_src_quo[OPW-2:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy && !o_dbz) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_div  <= i_divisor;
        r_cnt  <= CW'(OPW - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/calc_engine.sv
// ---------------------------------------------------------------------------
// calc_engine
//   Keypad calculator core: decimal operand entry, add/sub/mul/div, result
//   chaining and repeat-equal. Division runs on calc_divider.
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   calc_if.slave: key_en/key/equal in; out/neg/err/busy/valid out
//   W must be >= 2*OPW and match the W of the connected calc_if.
// ---------------------------------------------------------------------------
module calc_engine
  import calc_pkg::*;
#(
  parameter int OPW = 8,
  parameter int W   = 2 * OPW
) (
  input logic   clk,
  input logic   rst,
  calc_if.slave bus
);
  localparam logic [OPW+3:0] ACC_MAX = {4'd0, {OPW{1'b1}}};

  state_e         r_state, w_state_nxt;
  logic [OPW-1:0] r_a, w_a_nxt;
  logic [OPW-1:0] r_b, w_b_nxt;
  op_e            r_op, w_op_nxt;
  logic           r_b_seen, w_b_seen_nxt;
  logic [W-1:0]   r_res, w_res_nxt;
  logic           r_neg, w_neg_nxt;
  logic           r_valid, w_valid_nxt;

  logic           w_digit, w_oper, w_clear, w_equal;
  logic [OPW-1:0] w_key_val, w_a_acc, w_b_acc;
  logic           w_res_fits;
  logic [W-1:0]   w_alu_res;
  logic           w_alu_neg;
  logic [W-1:0]   w_out;

  logic           w_div_start, w_div_busy, w_div_done, w_div_dbz;
  logic [OPW-1:0] w_div_quo;

  // Decimal entry; a digit that would overflow the operand is dropped.
  function automatic logic [OPW-1:0] acc_digit(input logic [OPW-1:0] acc,
                                               input logic [3:0]     d);
    logic [OPW+3:0] sum;
    sum = (OPW+4)'(acc) * (OPW+4)'(10) + (OPW+4)'(d);
    return (sum > ACC_MAX) ? acc : sum[OPW-1:0];
  endfunction

  // key_en wins over a simultaneous equal; key 15 decodes to nothing.
  assign w_clear    = bus.key_en && (bus.key == KEY_CLR);
  assign w_digit    = bus.key_en && (bus.key <= KEY_DIGIT_MAX);
  assign w_oper     = bus.key_en && (bus.key >= KEY_ADD) && (bus.key <= KEY_DIV);
  assign w_equal    = bus.equal && !bus.key_en;
  assign w_key_val  = acc_digit('0, bus.key);
  assign w_a_acc    = acc_digit(r_a, bus.key);
  assign w_b_acc    = acc_digit(r_b, bus.key);
  assign w_res_fits = ~|r_res[W-1:OPW];

  // Start once on entry to CALC; busy/done keep it from re-firing.
  assign w_div_start = (r_state == ST_CALC) && (r_op == OP_DIV) &&
                       !w_div_busy && !w_div_done && !w_clear;

  calc_divider #(.OPW(OPW)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (w_clear),
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_dbz      (w_div_dbz),
    .o_quotient (w_div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_b_seen <= 1'b0;
      r_res    <= '0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_b_seen <= w_b_seen_nxt;
      r_res    <= w_res_nxt;
      r_neg    <= w_neg_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // otherwise an unassigned path would infer a latch.
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_b_seen_nxt = r_b_seen;
    w_res_nxt    = r_res;
    w_neg_nxt    = r_neg;
    w_valid_nxt  = 1'b0;

    if (w_clear) begin
      w_state_nxt  = ST_IDLE;
      w_a_nxt      = '0;
      w_b_nxt      = '0;
      w_op_nxt     = OP_ADD;
      w_b_seen_nxt = 1'b0;
      w_res_nxt    = '0;
      w_neg_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_digit) begin
            w_state_nxt = ST_OPA;
            w_a_nxt     = w_key_val;
          end else if (w_oper) begin
            w_state_nxt  = ST_OPB;
            w_a_nxt      = '0;
            w_b_nxt      = '0;
            w_b_seen_nxt = 1'b0;
            w_op_nxt     = key_to_op(bus.key);
          end
        end
        ST_OPA: begin
          if (w_digit) begin
            w_a_nxt = w_a_acc;
          end else if (w_oper) begin
            w_state_nxt  = ST_OPB;
            w_b_nxt      = '0;
            w_b_seen_nxt = 1'b0;
            w_op_nxt     = key_to_op(bus.key);
          end else if (w_equal) begin
            w_state_nxt = ST_RESULT;
            w_res_nxt   = W'(r_a);
            w_neg_nxt   = 1'b0;
          end
        end
        ST_OPB: begin
          if (w_digit) begin
            w_b_nxt      = w_b_acc;
            w_b_seen_nxt = 1'b1;
          end else if (w_oper && !r_b_seen) begin
            w_op_nxt = key_to_op(bus.key);
          end else if (w_equal) begin
            w_state_nxt = ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_op == OP_DIV) begin
            if (w_div_dbz) begin
              w_state_nxt = ST_ERROR;
              w_res_nxt   = '0;
              w_neg_nxt   = 1'b0;
            end else if (w_div_done) begin
              w_state_nxt = ST_RESULT;
              w_res_nxt   = W'(w_div_quo);
              w_neg_nxt   = 1'b0;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_RESULT;
            w_res_nxt   = w_alu_res;
            w_neg_nxt   = w_alu_neg;
            w_valid_nxt = 1'b1;
          end
        end
        ST_RESULT: begin
          if (w_digit) begin
            w_state_nxt = ST_OPA;
            w_a_nxt     = w_key_val;
            w_neg_nxt   = 1'b0;
          end else if (w_oper || w_equal) begin
            // Chaining and repeat-equal both reuse the result as A, which
            // only works for a non-negative result that fits an operand.
            if (!r_neg && w_res_fits) begin
              w_a_nxt = r_res[OPW-1:0];
              if (w_oper) begin
                w_state_nxt  = ST_OPB;
                w_b_nxt      = '0;
                w_b_seen_nxt = 1'b0;
                w_op_nxt     = key_to_op(bus.key);
              end else begin
                w_state_nxt = ST_CALC;
              end
            end else begin
              w_state_nxt = ST_ERROR;
              w_res_nxt   = '0;
              w_neg_nxt   = 1'b0;
            end
          end
        end
        ST_ERROR: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Single-cycle operators; division comes from the divider.
  always_comb begin
    w_alu_res = '0;
    w_alu_neg = 1'b0;
    unique case (r_op)
      OP_ADD: w_alu_res = W'({1'b0, r_a} + {1'b0, r_b});
      OP_SUB: begin
        if (r_a >= r_b) begin
          w_alu_res = W'(r_a - r_b);
        end else begin
          w_alu_res = W'(r_b - r_a);
          w_alu_neg = 1'b1;
        end
      end
      OP_MUL: w_alu_res = W'((2*OPW)'(r_a) * (2*OPW)'(r_b));
      default: ;
    endcase
  end

  always_comb begin
    unique case (r_state)
      ST_OPA:             w_out = W'(r_a);
      ST_OPB:             w_out = W'(r_b);
      ST_CALC, ST_RESULT: w_out = r_res;
      default:            w_out = '0;
    endcase
  end

  assign bus.out   = w_out;
  assign bus.neg   = r_neg;
  assign bus.err   = (r_state == ST_ERROR);
  assign bus.busy  = (r_state == ST_CALC);
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_calc_engine.sv
// ---------------------------------------------------------------------------
// tb_calc_engine
//   Directed scenarios followed by random key sequences for calc_engine
//   (OPW=8, W=16). Expected values come from a behavioural calculator model
//   that works on plain integers.
// ---------------------------------------------------------------------------
module tb_calc_engine;
  localparam int OPW  = 8;
  localparam int W    = 16;
  localparam int MAXV = (1 << OPW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_OPA  = 1;
  localparam int M_OPB  = 2;
  localparam int M_RES  = 3;
  localparam int M_ERR  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  calc_if #(.W(W)) bus ();

  calc_engine #(.OPW(OPW), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the calculator as a user sees it once computation has settled.
  int          m_mode;
  int unsigned m_a, m_b, m_res;
  int          m_op;          // 0 add, 1 sub, 2 mul, 3 div
  bit          m_b_seen;
  bit          m_neg;
  int          m_valid_exp;

  int busy_n, valid_n, valid_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned enter(input int unsigned acc, input int unsigned d);
    int unsigned s;
    s = acc * 10 + d;
    return (s > MAXV) ? acc : s;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_a = 0; m_b = 0; m_res = 0; m_op = 0;
    m_b_seen = 0; m_neg = 0; m_valid_exp = 0;
  endtask

  task automatic model_error();
    m_mode = M_ERR; m_res = 0; m_neg = 0;
  endtask

  task automatic model_compute();
    if (m_op == 3 && m_b == 0) begin
      model_error();
    end else begin
      m_neg = 0;
      case (m_op)
        0: m_res = m_a + m_b;
        1: begin
          if (m_a >= m_b) m_res = m_a - m_b;
          else begin m_res = m_b - m_a; m_neg = 1; end
        end
        2: m_res = m_a * m_b;
        default: m_res = m_a / m_b;
      endcase
      m_mode = M_RES;
      m_valid_exp = 1;
    end
  endtask

  task automatic model_step(input logic ken, input logic [3:0] k, input logic eq);
    int unsigned kv;
    kv = int'(k);
    m_valid_exp = 0;
    if (ken) begin
      if (kv == 14) model_reset();
      else if (kv <= 9) begin
        case (m_mode)
          M_IDLE: begin m_mode = M_OPA; m_a = kv; end
          M_OPA:  m_a = enter(m_a, kv);
          M_OPB:  begin m_b = enter(m_b, kv); m_b_seen = 1; end
          M_RES:  begin m_mode = M_OPA; m_a = kv; m_neg = 0; end
          default: ;
        endcase
      end else if (kv <= 13) begin
        case (m_mode)
          M_IDLE: begin m_mode = M_OPB; m_a = 0; m_b = 0; m_b_seen = 0; m_op = kv - 10; end
          M_OPA:  begin m_mode = M_OPB; m_b = 0; m_b_seen = 0; m_op = kv - 10; end
          M_OPB:  if (!m_b_seen) m_op = kv - 10;
          M_RES: begin
            if (!m_neg && m_res <= MAXV) begin
              m_a = m_res; m_b = 0; m_b_seen = 0; m_op = kv - 10; m_mode = M_OPB;
            end else model_error();
          end
          default: ;
        endcase
      end
    end else if (eq) begin
      case (m_mode)
        M_OPA: begin m_mode = M_RES; m_res = m_a; m_neg = 0; end
        M_OPB: model_compute();
        M_RES: begin
          if (!m_neg && m_res <= MAXV) begin m_a = m_res; model_compute(); end
          else model_error();
        end
        default: ;
      endcase
    end
  endtask

  function automatic int unsigned model_out();
    case (m_mode)
      M_OPA:   return m_a;
      M_OPB:   return m_b;
      M_RES:   return m_res;
      default: return 0;
    endcase
  endfunction

  task automatic strobe(input logic ken, input logic [3:0] k, input logic eq);
    @(negedge clk);
    bus.key_en = ken; bus.key = k; bus.equal = eq;
    @(negedge clk);
    bus.key_en = 1'b0; bus.key = 4'd0; bus.equal = 1'b0;
  endtask

  // Bounded wait for the engine to go idle, recording busy/valid activity.
  task automatic settle();
    busy_n = 0; valid_n = 0; valid_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.valid) begin valid_n++; valid_at = i; end
      if (!bus.busy) break;
      @(negedge clk);
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".out"},   32'(bus.out),   model_out());
    check({tag, ".neg"},   32'(bus.neg),   32'(m_neg));
    check({tag, ".err"},   32'(bus.err),   32'(m_mode == M_ERR));
    check({tag, ".busy"},  32'(bus.busy),  0);
    check({tag, ".valid"}, 32'(valid_n),   32'(m_valid_exp));
  endtask

  task automatic act(input logic ken, input logic [3:0] k, input logic eq, input string tag);
    strobe(ken, k, eq);
    settle();
    model_step(ken, k, eq);
    compare(tag);
  endtask

  task automatic key(input int k);
    act(1'b1, 4'(k), 1'b0, $sformatf("key%0d", k));
  endtask

  task automatic eql();
    act(1'b0, 4'd0, 1'b1, "equal");
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.valid) seen++;
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_en = 1'b0; bus.key = 4'd0; bus.equal = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst.out",   32'(bus.out),   0);
    check("rst.neg",   32'(bus.neg),   0);
    check("rst.err",   32'(bus.err),   0);
    check("rst.busy",  32'(bus.busy),  0);
    check("rst.valid", 32'(bus.valid), 0);

    // 123 + 45
    key(1); key(2); key(3); key(10); key(4); key(5); eql();
    check("add.latency", 32'(valid_at), 2);
    check("add.busy_cycles", 32'(busy_n), 1);
    check("add.out", 32'(bus.out), 168);
    check("add.neg", 32'(bus.neg), 0);

    // Dropped third digit, then 25 * 255
    key(14); key(2); key(5); key(6);
    check("drop.out", 32'(bus.out), 25);
    key(12); key(2); key(5); key(5); eql();
    check("mul.out", 32'(bus.out), 6375);

    // 7 - 9, then chaining a negative result
    key(14); key(7); key(11); key(9); eql();
    check("sub.out", 32'(bus.out), 2);
    check("sub.neg", 32'(bus.neg), 1);
    key(10);
    check("chain_neg.err", 32'(bus.err), 1);
    check("chain_neg.out", 32'(bus.out), 0);
    key(14);
    check("clr.err", 32'(bus.err), 0);

    // 200 / 7
    key(2); key(0); key(0); key(13); key(7); eql();
    check("div.busy_cycles", 32'(busy_n), 9);
    check("div.latency", 32'(valid_at), 10);
    check("div.out", 32'(bus.out), 28);

    // Same divide, cleared on its fourth busy cycle
    key(14); key(2); key(0); key(0); key(13); key(7);
    strobe(1'b0, 4'd0, 1'b1);
    model_step(1'b0, 4'd0, 1'b1);
    check("abort.busy_at_start", 32'(bus.busy), 1);
    @(negedge clk);
    strobe(1'b1, 4'd14, 1'b0);
    model_step(1'b1, 4'd14, 1'b0);
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.out", 32'(bus.out), 0);
    watch_no_valid("abort.no_valid", 12);
    valid_n = 0;
    compare("abort");

    // Divide by zero
    key(9); key(13); key(0); eql();
    check("dbz.err", 32'(bus.err), 1);
    check("dbz.busy_cycles", 32'(busy_n), 1);
    key(14);

    // Repeat equal
    key(5); key(10); key(3); eql();
    check("rep1.out", 32'(bus.out), 8);
    eql();
    check("rep2.out", 32'(bus.out), 11);
    check("rep2.valid", 32'(valid_n), 1);

    // key_en together with equal in OPB
    key(14); key(4); key(10); key(6);
    act(1'b1, 4'd7, 1'b1, "key_and_eq");
    check("key_and_eq.out", 32'(bus.out), 67);
    eql();
    check("key_and_eq.sum", 32'(bus.out), 71);

    // Operator replacement, ignored operator after B digit, key 15
    key(14); key(8); key(10); key(11); key(3); eql();
    check("op_replace.out", 32'(bus.out), 5);
    key(14); key(8); key(11); key(3); key(12); eql();
    check("op_after_b.out", 32'(bus.out), 5);
    key(14); key(4); key(15); key(2);
    check("key15.out", 32'(bus.out), 42);

    // Strobes during a divide are dropped
    key(14); key(2); key(0); key(0); key(13); key(7);
    strobe(1'b0, 4'd0, 1'b1);
    model_step(1'b0, 4'd0, 1'b1);
    strobe(1'b1, 4'd3, 1'b0);
    strobe(1'b0, 4'd0, 1'b1);
    settle();
    compare("busy_drop");
    check("busy_drop.out", 32'(bus.out), 28);

    // Reset in the middle of a divide
    key(14); key(9); key(9); key(13); key(4);
    strobe(1'b0, 4'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_mid.busy", 32'(bus.busy), 0);
    check("rst_mid.out", 32'(bus.out), 0);
    watch_no_valid("rst_mid.no_valid", 12);
    valid_n = 0;
    compare("rst_mid");

    // Random key sequences
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      act(1'b1, 4'($urandom_range(0, 9)), 1'b0, "rnd_digit");
      else if (r < 75) act(1'b1, 4'($urandom_range(10, 13)), 1'b0, "rnd_op");
      else if (r < 88) act(1'b0, 4'd0, 1'b1, "rnd_equal");
      else if (r < 93) act(1'b1, 4'd14, 1'b0, "rnd_clear");
      else if (r < 96) act(1'b1, 4'd15, 1'b0, "rnd_rsv");
      else             act(1'b1, 4'($urandom_range(0, 13)), 1'b1, "rnd_key_eq");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
